// File: rtl/riscorvo_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : riscorvo_data_mem
//  Purpose  : Wait-state-configurable data memory responder for the riscorvo
//             core data port. Captures one request, waits WAIT_STATES cycles,
//             then completes it with a one-cycle ready pulse (plus err_o for
//             addresses outside the window).
//  Revision : 1.0 - initial release
// ============================================================================
module riscorvo_data_mem #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_data_i,
  input  logic [31:0] addr_data_i,
  input  logic [31:0] write_data_i,
  input  logic        read_write_i,
  input  logic [3:0]  mask_data_i,
  output logic        ready_data_o,
  output logic [31:0] read_data_o,
  output logic        err_o
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              in_range_q, in_range_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [3:0]        mask_q, mask_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem_q [MEM_WORDS];
  logic              mem_we;
  logic [31:0]       mem_wdata;

  logic [32:0]       offset;
  logic              live_in_range;
  logic [IDX_W-1:0]  live_idx;

  // Decode the live address: 33-bit offset so addresses below BASE_ADDR
  // land far above the window instead of wrapping into it.
  always_comb begin
    offset        = {1'b0, addr_data_i} - {1'b0, BASE_ADDR};
    live_in_range = (offset < MEM_BYTES);
    live_idx      = offset[IDX_W+1:2];
  end

  // Next-state, request capture and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    mask_d     = mask_q;
    case (state_q)
      S_IDLE: begin
        if (valid_data_i) begin
          idx_d      = live_idx;
          in_range_d = live_in_range;
          wdata_d    = write_data_i;
          rw_d       = read_write_i;
          mask_d     = mask_data_i;
          cnt_d      = WS;
          state_d    = (WS == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Outputs are registered: decode them from the state being entered so
    // they are valid for exactly the RESP cycle.
    ready_d = (state_d == S_RESP);
    err_d   = ready_d && !in_range_d;
    rdata_d = (ready_d && !rw_d && in_range_d) ? mem_q[idx_d] : 32'h0;
  end

  // Byte-merge for the write committed at the edge that ends RESP.
  always_comb begin
    mem_we    = (state_q == S_RESP) && rw_q && in_range_q;
    mem_wdata = mem_q[idx_q];
    for (int b = 0; b < 4; b++) begin
      if (mask_q[b]) begin
        mem_wdata[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= mem_wdata;
    end
  end

  // Control, request and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      wdata_q    <= 32'h0;
      rw_q       <= 1'b0;
      mask_q     <= 4'h0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      mask_q     <= mask_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ready_data_o = ready_q;
  assign err_o        = err_q;
  assign read_data_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_riscorvo_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscorvo_data_mem
//  Purpose  : Directed self-checking bench for riscorvo_data_mem. Four
//             instances with WAIT_STATES = 0, 1, 3, 15 share clock and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscorvo_data_mem;

  localparam logic [31:0] B = 32'h0001_0000;

  logic        clk;
  logic        rst_n;
  logic        v   [4];
  logic [31:0] a   [4];
  logic [31:0] wd  [4];
  logic        rwv [4];
  logic [3:0]  m   [4];
  logic        rdy [4];
  logic [31:0] rd  [4];
  logic        er  [4];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  riscorvo_data_mem #(.MEM_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(B)) u_ws0 (
    .clk(clk), .reset_n(rst_n), .valid_data_i(v[0]), .addr_data_i(a[0]),
    .write_data_i(wd[0]), .read_write_i(rwv[0]), .mask_data_i(m[0]),
    .ready_data_o(rdy[0]), .read_data_o(rd[0]), .err_o(er[0]));

  riscorvo_data_mem #(.MEM_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(B)) u_ws1 (
    .clk(clk), .reset_n(rst_n), .valid_data_i(v[1]), .addr_data_i(a[1]),
    .write_data_i(wd[1]), .read_write_i(rwv[1]), .mask_data_i(m[1]),
    .ready_data_o(rdy[1]), .read_data_o(rd[1]), .err_o(er[1]));

  riscorvo_data_mem #(.MEM_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(B)) u_ws3 (
    .clk(clk), .reset_n(rst_n), .valid_data_i(v[2]), .addr_data_i(a[2]),
    .write_data_i(wd[2]), .read_write_i(rwv[2]), .mask_data_i(m[2]),
    .ready_data_o(rdy[2]), .read_data_o(rd[2]), .err_o(er[2]));

  riscorvo_data_mem #(.MEM_WORDS(1024), .WAIT_STATES(15), .BASE_ADDR(B)) u_ws15 (
    .clk(clk), .reset_n(rst_n), .valid_data_i(v[3]), .addr_data_i(a[3]),
    .write_data_i(wd[3]), .read_write_i(rwv[3]), .mask_data_i(m[3]),
    .ready_data_o(rdy[3]), .read_data_o(rd[3]), .err_o(er[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check, reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer on instance d. lat = k means ready seen in cycle N+k where
  // edge N is the capture edge; lat = 0 means no ready within the budget.
  task automatic xfer(input int d, input logic w, input logic [31:0] ad,
                      input logic [31:0] dat, input logic [3:0] msk,
                      output logic [31:0] rdo, output logic erro, output int lat);
    rdo  = 32'h0;
    erro = 1'b0;
    lat  = 0;
    @(negedge clk);
    v[d] = 1'b1; rwv[d] = w; a[d] = ad; wd[d] = dat; m[d] = msk;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (rdy[d]) begin
        lat  = k;
        rdo  = rd[d];
        erro = er[d];
        break;
      end
      @(posedge clk);
    end
    v[d] = 1'b0;
    @(posedge clk);
    #1;
    check("pulse_end", {31'd0, rdy[d]}, 32'd0);
    check("rdata_idle", rd[d], 32'd0);
  endtask

  // Valid held high for three back-to-back reads; checks pulse spacing.
  task automatic b2b(input int d, input int ws, input logic [31:0] ad);
    int t[3];
    int n;
    n = 0;
    @(negedge clk);
    v[d] = 1'b1; rwv[d] = 1'b0; a[d] = ad; m[d] = 4'hF;
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(posedge clk);
      #1;
      if (rdy[d]) begin
        t[n] = cyc;
        n++;
      end
    end
    v[d] = 1'b0;
    check("b2b_count", n, 3);
    if (n == 3) begin
      check("b2b_gap1", t[1] - t[0], ws + 2);
      check("b2b_gap2", t[2] - t[1], ws + 2);
    end
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          l;

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0; a[i] = 32'h0; wd[i] = 32'h0; rwv[i] = 1'b0; m[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_ready", {31'd0, rdy[i]}, 32'd0);
      check("rst_err", {31'd0, er[i]}, 32'd0);
      check("rst_rdata", rd[i], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single write then read, WAIT_STATES = 1
    xfer(1, 1'b1, B + 32'h8, 32'hDEADBEEF, 4'hF, r, e, l);
    check("wr_lat", l, 2);
    check("wr_err", {31'd0, e}, 32'd0);
    xfer(1, 1'b0, B + 32'h8, 32'h0, 4'h0, r, e, l);
    check("rd_lat", l, 2);
    check("rd_data", r, 32'hDEADBEEF);
    check("rd_err", {31'd0, e}, 32'd0);

    // Byte masking
    xfer(1, 1'b1, B + 32'h10, 32'h11223344, 4'hF, r, e, l);
    xfer(1, 1'b1, B + 32'h10, 32'hAABBCCDD, 4'b0101, r, e, l);
    xfer(1, 1'b0, B + 32'h10, 32'h0, 4'h0, r, e, l);
    check("mask_data", r, 32'h11BB33DD);
    xfer(1, 1'b1, B + 32'h10, 32'hFFFFFFFF, 4'h0, r, e, l);
    check("mask0_lat", l, 2);
    check("mask0_err", {31'd0, e}, 32'd0);
    xfer(1, 1'b0, B + 32'h10, 32'h0, 4'hF, r, e, l);
    check("mask0_data", r, 32'h11BB33DD);

    // Out of range
    xfer(1, 1'b0, B + 32'h1000, 32'h0, 4'hF, r, e, l);
    check("oor_rd_lat", l, 2);
    check("oor_rd_data", r, 32'h0);
    check("oor_rd_err", {31'd0, e}, 32'd1);
    xfer(1, 1'b1, B + 32'hFFC, 32'h12345678, 4'hF, r, e, l);
    check("top_wr_err", {31'd0, e}, 32'd0);
    xfer(1, 1'b1, B - 32'h4, 32'hFFFFFFFF, 4'hF, r, e, l);
    check("oor_wr_err", {31'd0, e}, 32'd1);
    xfer(1, 1'b0, B + 32'hFFC, 32'h0, 4'hF, r, e, l);
    check("top_rd_data", r, 32'h12345678);
    check("top_rd_err", {31'd0, e}, 32'd0);
    xfer(1, 1'b0, B + 32'h8, 32'h0, 4'hF, r, e, l);
    check("keep_data", r, 32'hDEADBEEF);

    // Latency sweep
    xfer(0, 1'b1, B + 32'h20, 32'hCAFEF00D, 4'hF, r, e, l);
    check("ws0_wr_lat", l, 1);
    xfer(0, 1'b0, B + 32'h20, 32'h0, 4'hF, r, e, l);
    check("ws0_rd_lat", l, 1);
    check("ws0_rd_data", r, 32'hCAFEF00D);
    xfer(2, 1'b1, B + 32'h24, 32'h0BADC0DE, 4'hF, r, e, l);
    check("ws3_wr_lat", l, 4);
    xfer(2, 1'b0, B + 32'h24, 32'h0, 4'hF, r, e, l);
    check("ws3_rd_lat", l, 4);
    check("ws3_rd_data", r, 32'h0BADC0DE);
    xfer(3, 1'b1, B + 32'h28, 32'h13572468, 4'hF, r, e, l);
    check("ws15_wr_lat", l, 16);
    xfer(3, 1'b0, B + 32'h28, 32'h0, 4'hF, r, e, l);
    check("ws15_rd_lat", l, 16);
    check("ws15_rd_data", r, 32'h13572468);

    b2b(0, 0, B + 32'h20);
    b2b(1, 1, B + 32'h8);
    b2b(2, 3, B + 32'h24);

    // Reset during WAIT of a write
    xfer(2, 1'b1, B + 32'h40, 32'h0, 4'hF, r, e, l);
    @(negedge clk);
    v[2] = 1'b1; rwv[2] = 1'b1; a[2] = B + 32'h40; wd[2] = 32'h5A5A5A5A; m[2] = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, rdy[2]}, 32'd0);
    v[2] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold_ready", {31'd0, rdy[2]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    xfer(2, 1'b0, B + 32'h40, 32'h0, 4'hF, r, e, l);
    check("post_rst_lat", l, 4);
    check("post_rst_data", r, 32'h0);

    // valid dropped during WAIT
    @(negedge clk);
    v[2] = 1'b1; rwv[2] = 1'b0; a[2] = B + 32'h24; m[2] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    v[2] = 1'b0;
    l = 0;
    for (int k = 2; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (rdy[2]) begin
        l = k;
        r = rd[2];
        break;
      end
    end
    check("drop_lat", l, 4);
    check("drop_data", r, 32'h0BADC0DE);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscorvo_data_mem.md
# riscorvo_data_mem

Wait-state-configurable data memory responder for the riscorvo core's data memory interface. It receives the core's valid/address/write-data/mask requests, performs byte-masked word writes or full-word reads on an internal array, and completes each transfer with a one-cycle ready pulse after a programmable latency. It is used in simulation benches and small FPGA builds as the counterpart of the core's data port. It also serves as a behavioural model of a slow peripheral bus.

## Interface
Parameters:
- MEM_WORDS, 1024: depth of the word array (32-bit words); power of two, at least 2.
- WAIT_STATES, 1: extra cycles between request capture and the ready pulse, 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to MEM_WORDS*4.

Ports:
- clk  in  1  clock, all state on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- valid_data_i  in  1  request valid from the core; held until ready_data_o.
- addr_data_i  in  32  byte address; bits [1:0] ignored.
- write_data_i  in  32  write data.
- read_write_i  in  1  1 = write, 0 = read.
- mask_data_i  in  4  byte enables for writes; bit i enables byte lane [8i+7:8i].
- ready_data_o  out  1  one-cycle completion pulse.
- read_data_o  out  32  read data, valid only while ready_data_o = 1.
- err_o  out  1  one-cycle pulse, coincident with ready_data_o, for an out-of-range address.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE behaviour:
  - On valid_data_i = 1, capture addr, wdata, rw and mask into request registers and load cnt = WAIT_STATES.
  - Go to RESP if WAIT_STATES = 0, otherwise go to WAIT.
- WAIT behaviour:
  - Decrement cnt each cycle.
  - When cnt = 1, go to RESP.
  - Live inputs are ignored; only the captured request is used.
- RESP behaviour:
  - ready_data_o = 1.
  - For a read, read_data_o = mem[index].
  - For a write, lanes with mask bit set are updated at the edge ending RESP.
  - The next state is always IDLE.
- Index and range check:
  - index = (addr - BASE_ADDR) >> 2.
  - The address is in range when BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS, using 33-bit compare (no wrap-around).
- Out-of-range access:
  - A read returns 32'h0.
  - A write modifies nothing.
  - ready_data_o and err_o both pulse in RESP.
- A write with mask 4'b0000 changes no byte and still completes normally.
- Reads ignore mask_data_i and always return the full word.
- If valid_data_i deasserts during WAIT (a protocol violation), the captured request still completes.
- A request presented in the cycle after RESP is accepted in IDLE as a new request.
- Reset:
  - Asynchronously forces IDLE and cnt = 0.
  - Forces ready_data_o = 0, err_o = 0 and read_data_o = 0.
  - Memory contents are not reset; an in-flight write is dropped.
- read_data_o is 32'h0 in every cycle outside RESP.

## Timing
- ready_data_o and err_o are registered outputs; read_data_o is registered-decoded from the FSM.
- Reset values: ready_data_o = 0, err_o = 0, read_data_o = 32'h0.
- Latency: with valid first seen high at edge N, ready_data_o is high during cycle N+1+WAIT_STATES.
- Throughput: one transfer per WAIT_STATES+2 cycles when the core keeps valid high back-to-back.
- Write visibility: a write completing in cycle R is visible to a read whose RESP is any cycle after R.
- Reset mid-transfer: ready_data_o is low from the reset assertion. The first valid after release is captured in the first clk edge with reset_n = 1.
- The core must not change request fields while valid is high and ready is low. The block samples them only at the capture edge.

## Test plan
- Single write then read, WAIT_STATES = 1:
  - Stimulus: write 32'hDEADBEEF to BASE_ADDR+8 with mask 4'hF, then read the same address.
  - Required response: each ready_data_o pulse is exactly 1 cycle, 2 cycles after valid is first seen high. The read returns 32'hDEADBEEF and err_o stays 0.
- Byte masking:
  - Stimulus: write 32'h11223344 with mask 4'hF, then write 32'hAABBCCDD with mask 4'b0101, then read.
  - Required response: the read returns 32'h11BB33DD.
  - Stimulus: a further write with mask 4'h0.
  - Required response: the following read still returns 32'h11BB33DD.
- Out of range, MEM_WORDS = 1024:
  - Stimulus: read from BASE_ADDR+32'h1000.
  - Required response: read_data_o = 0 and err_o pulses with ready_data_o.
  - Stimulus: write 32'hFFFFFFFF to BASE_ADDR-4.
  - Required response: err_o pulses and no in-range word changes.
  - Stimulus: access BASE_ADDR+32'hFFC.
  - Required response: err_o = 0.
- Latency sweep:
  - Stimulus: WAIT_STATES = 0, 3 and 15.
  - Required response: ready_data_o occurs at cycles N+1, N+4 and N+16.
  - Stimulus: valid held high continuously for back-to-back requests.
  - Required response: pulses are spaced exactly WAIT_STATES+2 cycles apart.
- Reset and protocol violation:
  - Stimulus: assert reset_n = 0 in WAIT of a write of 32'h5A5A5A5A to a word holding 32'h0.
  - Required response: ready_data_o stays low, the word still reads 32'h0 after release, and a fresh read completes with normal latency.
  - Stimulus: drop valid during WAIT.
  - Required response: the ready_data_o pulse still occurs.
